// File: rtl/fetch_controller.sv
// Instruction fetch controller: loads a program into instruction memory,
// then fetches sequentially into the IF/ID register with stall and branch
// redirect. A program that fills memory without a final word traps in ERR.
//
// Loader handshake: a word transfers on the rising edge where
// load_valid && load_ready; load_ready is high exactly while in LOAD, and
// load_valid/load_data/load_last must hold steady until that edge.
module fetch_controller #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_err,
  output logic [31:0] im_addr,
  output logic        im_we,
  output logic [31:0] im_wdata,
  input  logic [31:0] im_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        running,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] load_ptr_q;
  logic [AW-1:0] load_ptr_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   instr_q;
  logic [31:0]   pc4_q;
  logic          valid_q;
  logic          running_q;
  logic          err_q;
  logic          transfer;
  logic [31:0]   redirect_pc;

  assign transfer    = (state_q == S_LOAD) && load_valid;
  assign load_ptr_d  = load_ptr_q + AW'(1);
  assign pc_d        = pc_q + 32'd4;
  // Branch targets are forced word-aligned.
  assign redirect_pc = branch_target & ~32'h3;

  // Loader sees memory only in LOAD; afterwards the PC drives the address.
  always_comb begin
    load_ready = (state_q == S_LOAD);
    im_we      = transfer;
    im_wdata   = load_data;
    im_addr    = pc_q;
    if (state_q == S_LOAD) begin
      im_addr = 32'({load_ptr_q, 2'b00});
    end
  end

  // Single FSM: load sequencing, error trap, and PC / IF/ID update in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      load_ptr_q <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (transfer) begin
            load_ptr_q <= load_ptr_d;
            if (load_last) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
              pc_q      <= '0;
              valid_q   <= 1'b0;
            end else if (load_ptr_q == LAST_PTR) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Branch beats stall; stall beats normal fetch.
          if (branch_taken) begin
            pc_q    <= redirect_pc;
            instr_q <= '0;
            valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q <= im_rdata;
            pc4_q   <= pc_d;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
          end
        end
        S_ERR: begin
          // Trapped until reset; everything stays frozen.
          err_q     <= 1'b1;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= S_ERR;
          err_q     <= 1'b1;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign running     = running_q;
  assign load_err    = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural 4 KB instruction memory.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_err;
  logic [31:0] im_addr;
  logic        im_we;
  logic [31:0] im_wdata;
  logic [31:0] im_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        running;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_fail;

  fetch_controller #(.DEPTH_WORDS(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_err      (load_err),
    .im_addr       (im_addr),
    .im_we         (im_we),
    .im_wdata      (im_wdata),
    .im_rdata      (im_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .running       (running),
    .dbg_state_o   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read.
  assign im_rdata = mem[im_addr[11:2]];
  always @(posedge clk) begin
    if (im_we) mem[im_addr[11:2]] <= im_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset state, before any clock edge
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_running", {31'b0, running}, 32'h0);
    check("rst_ready", {31'b0, load_ready}, 32'h1);
    check("rst_err", {31'b0, load_err}, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_we", {31'b0, im_we}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-word program load
    load_valid = 1'b1; load_data = 32'hAD0A_0008; load_last = 1'b0;
    #1;
    check("ld0_we", {31'b0, im_we}, 32'h1);
    check("ld0_addr", im_addr, 32'h0);
    check("ld0_wdata", im_wdata, 32'hAD0A_0008);
    @(negedge clk);
    load_data = 32'h8D0B_0000; load_last = 1'b1;
    #1;
    check("ld1_addr", im_addr, 32'h4);
    check("ld1_we", {31'b0, im_we}, 32'h1);
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    check("run_running", {31'b0, running}, 32'h1);
    check("run_pc", pc, 32'h0);
    check("run_valid0", {31'b0, if_id_valid}, 32'h0);
    check("run_ready", {31'b0, load_ready}, 32'h0);
    check("run_we", {31'b0, im_we}, 32'h0);
    check("run_state", {30'b0, dbg_state}, 32'h1);
    check("mem0", mem[0], 32'hAD0A_0008);
    check("mem1", mem[1], 32'h8D0B_0000);

    // Sequential fetch
    exp_q.push_back(32'hAD0A_0008);
    exp_q.push_back(32'h8D0B_0000);
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      check("fetch_instr", if_id_instr, exp_q.pop_front());
      check("fetch_pc4", if_id_pc4, 32'(i * 4));
      check("fetch_pc", pc, 32'(i * 4));
      check("fetch_valid", {31'b0, if_id_valid}, 32'h1);
    end

    // Stall three cycles, then resume
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("stall_pc", pc, 32'h8);
      check("stall_instr", if_id_instr, 32'h8D0B_0000);
      check("stall_pc4", if_id_pc4, 32'h8);
      check("stall_valid", {31'b0, if_id_valid}, 32'h1);
    end
    stall = 1'b0;
    next_cycle();
    check("resume_instr", if_id_instr, 32'h1000_0002);
    check("resume_pc4", if_id_pc4, 32'hC);
    check("resume_pc", pc, 32'hC);

    // Branch wins over stall; target aligned
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_000E;
    next_cycle();
    check("br_pc", pc, 32'hC);
    check("br_valid", {31'b0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr, 32'h0);
    stall = 1'b0; branch_taken = 1'b0;
    next_cycle();
    check("post_br_instr", if_id_instr, 32'h1000_0003);
    check("post_br_pc4", if_id_pc4, 32'h10);
    check("post_br_valid", {31'b0, if_id_valid}, 32'h1);

    // PC wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    next_cycle();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_addr", im_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    next_cycle();
    check("wrap_instr", if_id_instr, 32'h1000_03FF);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_pc0", pc, 32'h0);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("rr_pc", pc, 32'h0);
    check("rr_instr", if_id_instr, 32'h0);
    check("rr_pc4", if_id_pc4, 32'h0);
    check("rr_valid", {31'b0, if_id_valid}, 32'h0);
    check("rr_running", {31'b0, running}, 32'h0);
    check("rr_ready", {31'b0, load_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Partial load, then asynchronous reset mid-load
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1; load_data = 32'h1111_0000 + k; load_last = 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    #1;
    check("ml_addr", im_addr, 32'hC);
    check("ml_mem2", mem[2], 32'h1111_0002);
    #1 rst_n = 1'b0;
    #1;
    check("ml_rst_addr", im_addr, 32'h0);
    check("ml_rst_we", {31'b0, im_we}, 32'h0);
    check("ml_rst_state", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow: 1024 words with no last marker
    for (int i = 0; i < 1024; i++) begin
      load_valid = 1'b1; load_data = 32'hA5A5_0000 ^ 32'(i); load_last = 1'b0;
      if (i == 0 || i == 1023) begin
        #1;
        check("ovf_addr", im_addr, 32'(i * 4));
      end
      @(negedge clk);
    end
    load_data = 32'hDEAD_BEEF;
    #1;
    check("ovf_err", {31'b0, load_err}, 32'h1);
    check("ovf_running", {31'b0, running}, 32'h0);
    check("ovf_ready", {31'b0, load_ready}, 32'h0);
    check("ovf_we", {31'b0, im_we}, 32'h0);
    check("ovf_state", {30'b0, dbg_state}, 32'h2);
    check("ovf_last_word", mem[1023], 32'hA5A5_03FF);
    check("ovf_word0", mem[0], 32'hA5A5_0000);
    branch_taken = 1'b1; branch_target = 32'h100;
    repeat (2) next_cycle();
    check("err_pc_frozen", pc, 32'h0);
    check("err_sticky", {31'b0, load_err}, 32'h1);
    check("err_mem0", mem[0], 32'hA5A5_0000);
    check("err_mem3", mem[3], 32'hA5A5_0003);
    branch_taken = 1'b0; load_valid = 1'b0;

    // Only reset leaves ERR
    rst_n = 1'b0;
    #1;
    check("err_rst_flag", {31'b0, load_err}, 32'h0);
    check("err_rst_state", {30'b0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit instruction-memory words (4 KB).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port load_valid  input  1  loader presents a program word.
REQ-005 The block SHALL have port load_data  input  32  program word to store.
REQ-006 The block SHALL have port load_last  input  1  qualifies the final word of the program.
REQ-007 The block SHALL have port load_ready  output  1  block accepts a loader word this cycle.
REQ-008 The block SHALL have port load_err  output  1  sticky program-overflow flag.
REQ-009 The block SHALL have port im_addr  output  32  byte address to instruction memory.
REQ-010 The block SHALL have port im_we  output  1  instruction-memory write enable.
REQ-011 The block SHALL have port im_wdata  output  32  instruction-memory write data.
REQ-012 The block SHALL have port im_rdata  input  32  combinational read data, word at im_addr>>2.
REQ-013 The block SHALL have port stall  input  1  hazard unit holds PC and IF/ID.
REQ-014 The block SHALL have port branch_taken  input  1  redirect request from a later stage.
REQ-015 The block SHALL have port branch_target  input  32  redirect byte address.
REQ-016 The block SHALL have port pc  output  32  current fetch address.
REQ-017 The block SHALL have port if_id_instr, if_id_pc4, if_id_valid  output  32/32/1  IF/ID pipeline register.
REQ-018 The block SHALL have port running  output  1  high in RUN state.

Function
REQ-019 The FSM SHALL have states LOAD, RUN and ERR; reset enters LOAD.
REQ-020 In LOAD: load_ready=1; im_addr=load_ptr*4; im_we=load_valid; im_wdata=load_data; the transfer occurs when load_valid&load_ready.
REQ-021 In LOAD, each transfer SHALL write the word at index load_ptr and increment load_ptr by 1.
REQ-022 A transfer with load_last=1 SHALL move the FSM to RUN on the next edge, with pc=0 and if_id_valid=0.
REQ-023 A transfer at load_ptr=DEPTH_WORDS-1 with load_last=0 SHALL still write the word and move the FSM to ERR.
REQ-024 In ERR: load_ready=0, im_we=0, load_err=1, running=0 and the PC frozen; only reset exits ERR.
REQ-025 In RUN and ERR: load_ready=0 and im_we=0; loader inputs are ignored.
REQ-026 In RUN: im_addr=pc.
REQ-027 RUN update precedence SHALL be branch_taken first, then stall, then normal fetch.
REQ-028 Normal fetch (no stall, no branch): if_id_instr<=im_rdata; if_id_pc4<=pc+4; if_id_valid<=1; pc<=pc+4. This gives one-cycle fetch latency.
REQ-029 branch_taken=1, regardless of stall: pc<=branch_target with bits[1:0] forced to 0; if_id_instr<=0; if_id_valid<=0 (flush bubble).
REQ-030 stall=1 with branch_taken=0 SHALL hold pc and all IF/ID registers unchanged.
REQ-031 PC arithmetic SHALL be modulo 2^32; memory index pc[log2(DEPTH_WORDS)+1:2] wraps to 0 past the last word.
REQ-032 stall and branch_taken SHALL be ignored outside RUN.

Reset
REQ-033 Asserting rst_n=0 at any time, including mid-load or mid-run, SHALL immediately set: state=LOAD, load_ptr=0, pc=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, load_err=0, running=0.
REQ-034 After reset, im_we SHALL be low until the first load_valid; instruction-memory contents are not cleared by reset.
REQ-035 Deassertion SHALL take effect on the first clk edge after rst_n rises.

Verification
REQ-036 Load 0xAD0A0008, 0x8D0B0000 (last on 2nd word) -> im_we pulses at addr 0, 4; running=1 the next cycle; pc=0.
REQ-037 Run after the load above, no stall -> if_id_instr=0xAD0A0008 with pc4=4, then 0x8D0B0000 with pc4=8; if_id_valid=1.
REQ-038 stall=1 for 3 cycles in RUN -> pc and if_id_* unchanged; resume -> fetch continues from the held pc.
REQ-039 branch_taken=1, stall=1, branch_target=0x0000000E -> pc=0x0000000C, if_id_valid=0, if_id_instr=0 on the next edge.
REQ-040 Stream 1024 words without load_last -> last word written at 0xFFC; ERR entered; load_err=1; further load_valid ignored.
REQ-041 rst_n pulsed low mid-run and mid-load -> all outputs at reset values asynchronously; LOAD restarts at address 0.
